ov7670_config_seq: RTL and testbench
====================================

# ov7670_config_seq

Sequencer that walks the OV7670 configuration ROM from address 0 and issues one SCCB register write per 16-bit entry: high byte = register address, low byte = value. It interprets the ROM markers `16'hFFF0` (insert fixed delay) and `16'hFFFF` (end of table). It sits between the config ROM and the SCCB write engine, and raises `done` once the camera is configured.

## Interface
Parameters:
- CLK_FREQ_HZ, 25_000_000, clk frequency, used to size the delay
- DELAY_MS, 10, length of the `FFF0` delay in milliseconds
- DELAY_CYCLES, CLK_FREQ_HZ/1000*DELAY_MS, derived; do not override

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to run the table from address 0
- rom_addr  out  8  ROM address; ROM output is registered (1-cycle read latency)
- rom_data  in  16  ROM entry for the address presented on the previous edge
- sccb_start  out  1  write request to the SCCB engine
- sccb_reg  out  8  register address; stable while sccb_start is high
- sccb_val  out  8  register value; stable while sccb_start is high
- sccb_ready  in  1  SCCB engine is idle and can accept a write
- busy  out  1  sequence in progress
- done  out  1  table finished; held until the next accepted start

## Operation
- States: IDLE, FETCH, LATCH, DECODE, SEND, WAIT_LOW, WAIT_HIGH, DELAY, DONE.
- IDLE/DONE, start=1:
  - rom_addr←0, busy←1, done←0, go to FETCH.
  - start is ignored in every other state.
- FETCH → LATCH: one cycle, lets the ROM sample rom_addr.
- LATCH: register rom_data into an internal entry register, then go to DECODE.
- DECODE:
  - entry==FFFF → DONE (busy←0, done←1).
  - entry==FFF0 → DELAY, load counter with DELAY_CYCLES-1.
  - otherwise → SEND, with sccb_reg←entry[15:8] and sccb_val←entry[7:0].
- SEND:
  - Hold sccb_start=1 until a cycle where sccb_start && sccb_ready. That cycle is the handshake.
  - After the handshake: sccb_start←0, go to WAIT_LOW.
- WAIT_LOW: wait for sccb_ready=0 (engine has taken the write), then WAIT_HIGH.
- WAIT_HIGH: wait for sccb_ready=1 (write finished), then advance.
- DELAY: decrement the counter; at 0, advance.
- Advance:
  - rom_addr==255 → DONE. This is the hard stop; there is no wrap.
  - otherwise rom_addr←rom_addr+1, go to FETCH.
- sccb_reg/sccb_val change only in DECODE. They keep the last written value afterwards.
- SCCB NACK/error is not handled here; the engine's ready handshake is the only completion signal.

## Timing
- Reset values:
  - rom_addr=0, sccb_start=0, sccb_reg=0, sccb_val=0, busy=0, done=0, state IDLE, delay counter 0.
- Reset mid-sequence: immediate return to IDLE with the values above. The SCCB engine is not notified.
- start sampled at edge k → busy=1 and rom_addr=0 after edge k.
- ROM read: FETCH+LATCH = 2 cycles from a rom_addr change to the entry being registered.
- Write entry:
  - sccb_start rises 3 cycles after rom_addr is updated (FETCH, LATCH, DECODE).
  - With sccb_ready already high, sccb_start is high for exactly 1 cycle.
- Delay entry: exactly DELAY_CYCLES cycles in DELAY, then FETCH of the next address.
- Per-entry overhead excluding SCCB time: 5 cycles for a write (FETCH, LATCH, DECODE, SEND, advance via WAIT_HIGH).
- Start asserted on the same edge that DONE is entered: ignored. It is honoured from DONE one cycle later.
- done falls and busy rises on the same edge.

## Structure
- Shared package `ov7670_pkg`:
  - ROM_END=16'hFFFF and ROM_DELAY=16'hFFF0.
  - State enumeration.
  - The same marker constants must be used by the ROM contents.
- One sub-module: `delay_counter` (load, enable, zero flag, width $clog2(DELAY_CYCLES)).
- Everything else in a single FSM module.

## Test plan
- ROM model {0:1280, 1:FFF0, 2:1210, 3:FFFF}, SCCB model ready low for 20 cycles per write, DELAY_CYCLES=50:
  - Exactly two writes, (12,80) then (12,10).
  - 50 idle cycles between them.
  - done=1 after address 3; rom_addr never exceeds 3.
- sccb_ready held low for 100 cycles during SEND → sccb_start stays high with sccb_reg/sccb_val unchanged. The handshake happens on the first ready=1 cycle.
- ROM returning 0x0C04 at every address (no FFFF) → 256 writes, then done=1. rom_addr stops at 255.
- start pulsed while busy → ignored, no restart. start after done → done=0 and a second full run identical to the first.
- rst_n pulled low during WAIT_HIGH and during DELAY → all outputs 0 immediately, asynchronously. A new start begins again at address 0.
- First entry FFFF → done=1 four cycles after start, with no sccb_start pulse.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 configuration path: ROM marker words and
// the sequencer state encoding. The config ROM contents use the same markers.
package ov7670_pkg;

  localparam logic [15:0] ROM_END   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_SEND,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_DELAY,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/delay_counter.sv
// Down-counter for the fixed FFF0 delay. A load presets DELAY_CYCLES-1, each
// enabled cycle counts down, and the count parks at zero so the zero flag
// stays valid until the next load.
module delay_counter #(
  parameter int unsigned DELAY_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic zero
);

  localparam int unsigned WIDTH = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(DELAY_CYCLES - 1);

  logic [WIDTH-1:0] count;

  assign zero = (count == '0);

  // load has priority; count down while enabled and not yet at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (enable && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/ov7670_config_seq.sv
// Walks the OV7670 configuration ROM from address 0 and hands each entry to
// the SCCB write engine as (register, value). FFF0 inserts a fixed delay,
// FFFF ends the table, and address 255 is a hard stop without wrap.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | waiting for start after reset
//   FETCH      | rom_addr presented, ROM samples it on this edge
//   LATCH      | ROM output registered into the entry register
//   DECODE     | classify entry: end marker, delay marker or register write
//   SEND       | sccb_start held high until the engine reports ready
//   WAIT_LOW   | waiting for the engine to drop ready (write taken)
//   WAIT_HIGH  | waiting for the engine to raise ready (write finished)
//   DELAY      | fixed delay running in delay_counter
//   DONE       | table finished, done held until the next start
module ov7670_config_seq
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
  parameter int unsigned DELAY_MS     = 10,
  parameter int unsigned DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sccb_start,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_val,
  input  logic        sccb_ready,
  output logic        busy,
  output logic        done
);

  seq_state_t  state;
  logic [15:0] entry;
  logic        dly_load;
  logic        dly_en;
  logic        dly_zero;
  logic        last_addr;

  assign dly_load  = (state == S_DECODE) && (entry == ROM_DELAY);
  assign dly_en    = (state == S_DELAY);
  assign last_addr = (rom_addr == 8'hFF);

  delay_counter #(
    .DELAY_CYCLES(DELAY_CYCLES)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (dly_load),
    .enable(dly_en),
    .zero  (dly_zero)
  );

  // sequencer: ROM walk, SCCB handshake and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rom_addr   <= '0;
      entry      <= '0;
      sccb_start <= 1'b0;
      sccb_reg   <= '0;
      sccb_val   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rom_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          entry <= rom_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (entry == ROM_END) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (entry == ROM_DELAY) begin
            state <= S_DELAY;
          end else begin
            sccb_reg   <= entry[15:8];
            sccb_val   <= entry[7:0];
            sccb_start <= 1'b1;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (sccb_ready) begin
            sccb_start <= 1'b0;
            state      <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!sccb_ready) state <= S_WAIT_HIGH;
        end
        S_WAIT_HIGH, S_DELAY: begin
          // both leave on completion: write finished or delay expired
          if ((state == S_WAIT_HIGH) ? sccb_ready : dly_zero) begin
            if (last_addr) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq. For every run the bench walks the ROM image
// itself and lays out a cycle timeline (expected outputs plus the ready and
// start stimulus) from the per-entry timing rules; the DUT is then driven from
// that timeline and compared on every negative edge.
module tb_ov7670_config_seq;
  import ov7670_pkg::*;

  localparam int CLK_HZ = 5000;
  localparam int DMS    = 10;
  localparam int D      = CLK_HZ / 1000 * DMS;   // 50 delay cycles
  localparam int MAXT   = 8192;
  localparam int TAIL   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sccb_ready = 1'b1;
  logic [7:0]  rom_addr, sccb_reg, sccb_val;
  logic [15:0] rom_data;
  logic        sccb_start, busy, done;

  always #5 clk = ~clk;

  ov7670_config_seq #(.CLK_FREQ_HZ(CLK_HZ), .DELAY_MS(DMS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .sccb_start(sccb_start), .sccb_reg(sccb_reg),
    .sccb_val(sccb_val), .sccb_ready(sccb_ready), .busy(busy), .done(done)
  );

  // registered ROM model
  logic [15:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // timeline
  logic [7:0] e_addr [MAXT];
  logic [7:0] e_reg  [MAXT];
  logic [7:0] e_val  [MAXT];
  bit         e_start[MAXT];
  bit         e_busy [MAXT];
  bit         e_done [MAXT];
  bit         d_ready[MAXT];
  bit         d_start[MAXT];
  int         plan_len, plan_done_t, wh_t, dl_t;
  logic [15:0] exp_wr[$];
  logic [15:0] act_wr[$];
  int          hs_t[$];
  logic [7:0]  m_reg = 8'h00, m_val = 8'h00;

  int n_checks = 0, n_err = 0;
  bit tl_on = 1'b0;
  int tl_idx = 0;
  int first_done_t, max_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s t=%0d actual=0x%0h required=0x%0h", nm, tl_idx, act, req);
    end
  endtask

  // compare process: DUT outputs against the timeline, mid-cycle
  always @(negedge clk) begin
    if (tl_on) begin
      chk("rom_addr",   32'(rom_addr),   32'(e_addr[tl_idx]));
      chk("sccb_start", 32'(sccb_start), 32'(e_start[tl_idx]));
      chk("sccb_reg",   32'(sccb_reg),   32'(e_reg[tl_idx]));
      chk("sccb_val",   32'(sccb_val),   32'(e_val[tl_idx]));
      chk("busy",       32'(busy),       32'(e_busy[tl_idx]));
      chk("done",       32'(done),       32'(e_done[tl_idx]));
      if (sccb_start && sccb_ready) begin
        act_wr.push_back({sccb_reg, sccb_val});
        hs_t.push_back(tl_idx);
      end
      if (done && first_done_t < 0) first_done_t = tl_idx;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    end
  end

  task automatic fill(input int t0, input int t1, input int a, input logic [7:0] r,
                      input logic [7:0] v, input bit bz, input bit dn);
    for (int k = t0; k < t1 && k < MAXT; k++) begin
      e_addr[k] = 8'(a);
      e_reg[k]  = r;
      e_val[k]  = v;
      e_busy[k] = bz;
      e_done[k] = dn;
    end
  endtask

  // walk the ROM image and lay out the expected cycle timeline
  task automatic build_plan(input int smin, input int smax, input int lmin, input int lmax,
                            input bit noise, input bit tail_start);
    int t, nt, a, s, l;
    logic [7:0] r, v;
    logic [15:0] e;
    bit fin;
    t = 0; a = 0; fin = 1'b0; r = m_reg; v = m_val;
    exp_wr.delete();
    wh_t = -1; dl_t = -1;
    for (int i = 0; i < MAXT; i++) begin
      e_start[i] = 1'b0; d_ready[i] = 1'b1; d_start[i] = 1'b0;
    end
    while (!fin) begin
      e = rom_mem[a];
      if (e == ROM_END) begin
        fill(t, t + 3, a, r, v, 1'b1, 1'b0);
        plan_done_t = t + 3;
        fin = 1'b1;
      end else if (e == ROM_DELAY) begin
        nt = t + 3 + D;
        fill(t, nt, a, r, v, 1'b1, 1'b0);
        if (dl_t < 0) dl_t = t + 13;
        t = nt;
      end else begin
        s  = int'($urandom_range(smax, smin));
        l  = int'($urandom_range(lmax, lmin));
        nt = t + 5 + s + l;
        fill(t, t + 3, a, r, v, 1'b1, 1'b0);
        r = e[15:8]; v = e[7:0];
        fill(t + 3, nt, a, r, v, 1'b1, 1'b0);
        for (int k = t + 3; k <= t + 3 + s && k < MAXT; k++) e_start[k] = 1'b1;
        for (int k = t + 3; k < t + 3 + s && k < MAXT; k++) d_ready[k] = 1'b0;
        for (int k = t + 4 + s; k < t + 4 + s + l && k < MAXT; k++) d_ready[k] = 1'b0;
        if (wh_t < 0 && l >= 2) wh_t = t + 5 + s;
        exp_wr.push_back(e);
        t = nt;
      end
      if (!fin) begin
        if (a == 255) begin
          plan_done_t = t;
          fin = 1'b1;
        end else begin
          a++;
        end
      end
    end
    plan_len = plan_done_t + TAIL;
    if (plan_len > MAXT) begin
      $display("FAIL plan_length actual=%0d required<=%0d", plan_len, MAXT);
      $fatal(1, "timeline overflow");
    end
    fill(plan_done_t, plan_len, a, r, v, 1'b0, 1'b1);
    if (noise)
      for (int i = 0; i < 4; i++) d_start[$urandom_range(plan_done_t - 1, 0)] = 1'b1;
    if (tail_start) d_start[plan_done_t - 1] = 1'b1;
    m_reg = r; m_val = v;
  endtask

  // abort_sel: 0 none, 1 reset inside WAIT_HIGH, 2 reset inside DELAY
  task automatic run(input int smin, input int smax, input int lmin, input int lmax,
                     input bit noise, input bit tail_start, input int abort_sel);
    int ab;
    ab = -1;
    build_plan(smin, smax, lmin, lmax, noise, tail_start);
    if (abort_sel == 1) ab = wh_t;
    if (abort_sel == 2) ab = dl_t;
    if (abort_sel != 0 && ab < 0) begin
      n_checks++; n_err++;
      $display("FAIL abort_point actual=none required=found");
    end
    act_wr.delete(); hs_t.delete(); first_done_t = -1; max_addr = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #2;
    tl_idx = 0; start = d_start[0]; sccb_ready = d_ready[0]; tl_on = 1'b1;
    for (int t = 1; t < plan_len; t++) begin
      @(posedge clk); #2;
      if (t == ab) begin
        tl_on = 1'b0;
        tl_idx = t;
        rst_n = 1'b0;
        #1;
        chk("rst_rom_addr",   32'(rom_addr),   32'd0);
        chk("rst_sccb_start", 32'(sccb_start), 32'd0);
        chk("rst_sccb_reg",   32'(sccb_reg),   32'd0);
        chk("rst_sccb_val",   32'(sccb_val),   32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_done",       32'(done),       32'd0);
        start = 1'b0; sccb_ready = 1'b1;
        m_reg = 8'h00; m_val = 8'h00;
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      tl_idx = t; start = d_start[t]; sccb_ready = d_ready[t];
    end
    @(posedge clk); #2;
    tl_on = 1'b0; start = 1'b0; sccb_ready = 1'b1;
    chk("write_count", 32'(act_wr.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i])
      chk("write_data", (i < act_wr.size()) ? 32'(act_wr[i]) : 32'hDEAD_BEEF, 32'(exp_wr[i]));
  endtask

  task automatic load_rom_random();
    int n;
    for (int i = 0; i < 256; i++) rom_mem[i] = {8'($urandom_range(254, 0)), 8'($urandom)};
    n = int'($urandom_range(12, 3));
    for (int i = 0; i < n; i++)
      if ($urandom_range(5, 0) == 0) rom_mem[i] = ROM_DELAY;
    rom_mem[n] = ROM_END;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = ROM_END;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rom_addr",   32'(rom_addr),   32'd0);
    chk("reset_sccb_start", 32'(sccb_start), 32'd0);
    chk("reset_sccb_reg",   32'(sccb_reg),   32'd0);
    chk("reset_sccb_val",   32'(sccb_val),   32'd0);
    chk("reset_busy",       32'(busy),       32'd0);
    chk("reset_done",       32'(done),       32'd0);
    @(negedge clk); rst_n = 1'b1;

    // reference table, ready low 20 cycles per write, then a repeat with
    // stray starts while busy and one on the edge that enters DONE
    rom_mem[0] = 16'h1280; rom_mem[1] = ROM_DELAY; rom_mem[2] = 16'h1210; rom_mem[3] = ROM_END;
    for (int pass = 0; pass < 2; pass++) begin
      run(0, 0, 20, 20, pass == 1, pass == 1, 0);
      chk("tbl_writes",   32'(act_wr.size()), 32'd2);
      chk("tbl_wr0",      (act_wr.size() > 0) ? 32'(act_wr[0]) : 32'hDEAD_BEEF, 32'h1280);
      chk("tbl_wr1",      (act_wr.size() > 1) ? 32'(act_wr[1]) : 32'hDEAD_BEEF, 32'h1210);
      chk("tbl_hs0_t",    (hs_t.size() > 0) ? 32'(hs_t[0]) : 32'hFFFF_FFFF, 32'd3);
      chk("tbl_hs1_t",    (hs_t.size() > 1) ? 32'(hs_t[1]) : 32'hFFFF_FFFF, 32'd81);
      chk("tbl_done_t",   32'(first_done_t),  32'd106);
      chk("tbl_max_addr", 32'(max_addr),      32'd3);
    end

    // ready held low for 100 cycles during SEND
    rom_mem[0] = 16'h3A5C; rom_mem[1] = ROM_END;
    run(100, 100, 3, 3, 0, 0, 0);
    chk("stall_hs_t",   (hs_t.size() > 0) ? 32'(hs_t[0]) : 32'hFFFF_FFFF, 32'd103);
    chk("stall_done_t", 32'(first_done_t), 32'd111);

    // first entry is the end marker
    rom_mem[0] = ROM_END;
    run(0, 0, 1, 1, 0, 0, 0);
    chk("empty_writes", 32'(act_wr.size()), 32'd0);
    chk("empty_done_t", 32'(first_done_t),  32'd3);

    // no end marker anywhere: hard stop at address 255
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0C04;
    run(0, 0, 1, 1, 1, 0, 0);
    chk("full_writes",   32'(act_wr.size()), 32'd256);
    chk("full_max_addr", 32'(max_addr),      32'd255);
    chk("full_done_t",   32'(first_done_t),  32'd1536);

    // reset during WAIT_HIGH, then during DELAY, each followed by a clean run
    for (int i = 0; i < 256; i++) rom_mem[i] = ROM_END;
    rom_mem[0] = 16'h4455; rom_mem[1] = ROM_DELAY; rom_mem[2] = 16'h6677; rom_mem[3] = ROM_END;
    run(0, 2, 3, 6, 0, 0, 1);
    run(0, 2, 3, 6, 0, 0, 0);
    chk("after_rst_writes", 32'(act_wr.size()), 32'd2);
    run(0, 2, 3, 6, 0, 0, 2);
    run(0, 2, 3, 6, 1, 0, 0);

    // randomized tables and SCCB timing
    for (int r = 0; r < 8; r++) begin
      load_rom_random();
      run(0, 4, 1, 6, 1, r[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
